pc_sequencer: RTL and testbench

//  Owns the program counter and drives the 3-bit select of the 5-input next-PC mux (mux_32_5).

---
 rtl/mips_pkg.sv | 11 +
 rtl/pc_sequencer.sv | 75 +++++++
 tb/tb_pc_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared next-PC mux select codes and sequencer state encoding
package mips_pkg;
  localparam logic [2:0] PCSRC_SEQ = 3'b000;
  localparam logic [2:0] PCSRC_BR  = 3'b001;
  localparam logic [2:0] PCSRC_J   = 3'b010;
  localparam logic [2:0] PCSRC_JR  = 3'b011;
  localparam logic [2:0] PCSRC_EXC = 3'b100;
  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
endpackage

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, selects the next-PC source and flushes the front end after redirects
module pc_sequencer import mips_pkg::*; #(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
  parameter int                  FLUSH_CYCLES = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic                jump,
  input  logic                jr,
  input  logic                exception,
  input  logic                exc_clear,
  input  logic [PC_WIDTH-1:0] next_pc,
  output logic [2:0]          pc_source,
  output logic                pc_write,
  output logic [PC_WIDTH-1:0] pc,
  output logic                flush,
  output logic [PC_WIDTH-1:0] epc,
  output logic                in_exception
);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  logic [1:0]          r_state;
  logic [2:0]          r_flush_cnt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_epc;
  logic                r_flush;
  logic                r_in_exc;
  logic                w_exc_take;
  logic                w_redirect;
  assign pc           = r_pc;
  assign epc          = r_epc;
  assign flush        = r_flush;
  assign in_exception = r_in_exc;
  // Select the next-PC source by priority; control transfers are only honoured in RUN
  always_comb begin
    w_exc_take = exception && !r_in_exc && r_state != ST_BOOT;
    w_redirect = r_state == ST_RUN && !stall && (jr || jump || branch_taken);
    pc_source  = w_exc_take ? PCSRC_EXC :
                 !w_redirect ? PCSRC_SEQ :
                 jr ? PCSRC_JR : jump ? PCSRC_J : PCSRC_BR;
    pc_write   = r_state != ST_BOOT && (w_exc_take || !stall);
  end
  // PC, exception bookkeeping and the BOOT/RUN/FLUSH sequencing
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_BOOT;
      r_flush_cnt <= '0;
      r_pc        <= RESET_PC;
      r_epc       <= '0;
      r_flush     <= 1'b0;
      r_in_exc    <= 1'b0;
    end else begin
      if (pc_write) r_pc <= next_pc;
      if (w_exc_take) r_epc <= r_pc;
      if (w_exc_take) r_in_exc <= 1'b1;
      else if (exc_clear) r_in_exc <= 1'b0;
      if (r_state == ST_BOOT) begin
        r_state <= ST_RUN;
      end else if (w_exc_take || w_redirect) begin
        r_state     <= ST_FLUSH;
        r_flush     <= 1'b1;
        r_flush_cnt <= FLUSH_LOAD;
      end else if (r_state == ST_FLUSH && !stall) begin
        if (r_flush_cnt == '0) begin
          r_state <= ST_RUN;
          r_flush <= 1'b0;
        end else begin
          r_flush_cnt <= r_flush_cnt - 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: two sequencers (1 and 3 flush bubbles) checked against a behavioural model
module tb_pc_sequencer;
  localparam logic [31:0] EXC_VEC = 32'h8000_0180;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, jr = 1'b0;
  logic exception = 1'b0, exc_clear = 1'b0;
  logic [31:0] br_tgt = '0, j_tgt = '0, jr_tgt = '0;
  logic [2:0]  src [2];
  logic        wr  [2];
  logic [31:0] pc  [2];
  logic [31:0] epc [2];
  logic        fl  [2];
  logic        ie  [2];
  logic [31:0] npc0, npc1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_pc   [2] = '{32'h0, 32'h0};
  logic [31:0] m_epc  [2] = '{32'h0, 32'h0};
  logic        m_boot [2] = '{1'b1, 1'b1};
  logic        m_ie   [2] = '{1'b0, 1'b0};
  int          m_left [2] = '{0, 0};

  always #5 clock = ~clock;

  function automatic logic [31:0] mux(input logic [2:0] s, input logic [31:0] p, b, j, r);
    case (s)
      3'd0: return p + 32'd4;
      3'd1: return b;
      3'd2: return j;
      3'd3: return r;
      3'd4: return EXC_VEC;
      default: return 32'h0;
    endcase
  endfunction

  assign npc0 = mux(src[0], pc[0], br_tgt, j_tgt, jr_tgt);
  assign npc1 = mux(src[1], pc[1], br_tgt, j_tgt, jr_tgt);

  pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .FLUSH_CYCLES(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
    .jump(jump), .jr(jr), .exception(exception), .exc_clear(exc_clear), .next_pc(npc0),
    .pc_source(src[0]), .pc_write(wr[0]), .pc(pc[0]), .flush(fl[0]), .epc(epc[0]),
    .in_exception(ie[0]));

  pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .FLUSH_CYCLES(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
    .jump(jump), .jr(jr), .exception(exception), .exc_clear(exc_clear), .next_pc(npc1),
    .pc_source(src[1]), .pc_write(wr[1]), .pc(pc[1]), .flush(fl[1]), .epc(epc[1]),
    .in_exception(ie[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int bubbles(input int i);
    return i == 0 ? 1 : 3;
  endfunction

  // Expected select/write from the rules: boot fetch, unmasked exception, stall, bubble, transfer
  function automatic void m_sel(input int i, output logic [2:0] s, output logic w);
    logic exc_ok;
    exc_ok = exception && !m_ie[i] && !m_boot[i];
    if (m_boot[i]) begin s = 3'd0; w = 1'b0; end
    else if (exc_ok) begin s = 3'd4; w = 1'b1; end
    else if (stall) begin s = 3'd0; w = 1'b0; end
    else if (m_left[i] > 0) begin s = 3'd0; w = 1'b1; end
    else begin s = jr ? 3'd3 : jump ? 3'd2 : branch_taken ? 3'd1 : 3'd0; w = 1'b1; end
  endfunction

  always @(posedge clock or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      automatic logic [2:0] s;
      automatic logic w;
      automatic logic exc_ok;
      if (!reset_n) begin
        m_pc[i] <= 32'h0; m_epc[i] <= 32'h0; m_boot[i] <= 1'b1; m_ie[i] <= 1'b0; m_left[i] <= 0;
      end else begin
        m_sel(i, s, w);
        exc_ok = exception && !m_ie[i] && !m_boot[i];
        if (w) m_pc[i] <= mux(s, m_pc[i], br_tgt, j_tgt, jr_tgt);
        m_boot[i] <= 1'b0;
        if (exc_ok) begin
          m_epc[i] <= m_pc[i];
          m_ie[i] <= 1'b1;
          m_left[i] <= bubbles(i);
        end else begin
          if (exc_clear) m_ie[i] <= 1'b0;
          if (!stall && m_left[i] > 0) m_left[i] <= m_left[i] - 1;
          else if (!stall && s != 3'd0) m_left[i] <= bubbles(i);
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      automatic logic [2:0] s;
      automatic logic w;
      m_sel(i, s, w);
      chk($sformatf("dut%0d.pc_source", i), 32'(src[i]), 32'(s));
      chk($sformatf("dut%0d.pc_write", i), 32'(wr[i]), 32'(w));
      chk($sformatf("dut%0d.pc", i), pc[i], m_pc[i]);
      chk($sformatf("dut%0d.flush", i), 32'(fl[i]), 32'(m_left[i] > 0));
      chk($sformatf("dut%0d.epc", i), epc[i], m_epc[i]);
      chk($sformatf("dut%0d.in_exception", i), 32'(ie[i]), 32'(m_ie[i]));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    chk("rst pc", pc[0], 32'h0);
    chk("rst epc", epc[0], 32'h0);
    chk("rst flush", 32'(fl[0]), 32'h0);
    chk("rst in_exc", 32'(ie[0]), 32'h0);
    chk("rst pc_write", 32'(wr[0]), 32'h0);
    chk("rst pc_source", 32'(src[0]), 32'h0);
    reset_n = 1'b1;
    #1;
    chk("boot pc_write", 32'(wr[0]), 32'h0);
    step(); chk("seq pc0", pc[0], 32'h0); chk("seq write", 32'(wr[0]), 32'h1);
    step(); chk("seq pc4", pc[0], 32'h4);
    step(); chk("seq pc8", pc[0], 32'h8);
    step(); chk("seq pc12", pc[0], 32'hC); chk("seq src", 32'(src[0]), 32'h0);
    step(); chk("seq pc16", pc[0], 32'h10);
    br_tgt = 32'h40; branch_taken = 1'b1;
    #1; chk("br src", 32'(src[0]), 32'h1);
    step(); chk("br pc", pc[0], 32'h40); chk("br flush", 32'(fl[0]), 32'h1);
    #1; chk("br ignored in flush", 32'(src[0]), 32'h0);
    step(); branch_taken = 1'b0;
    chk("br after pc", pc[0], 32'h44); chk("br flush drop", 32'(fl[0]), 32'h0);
    chk("br flush3 held", 32'(fl[1]), 32'h1);
    repeat (3) step();
    chk("resync pc", pc[1], 32'h50);
    jr_tgt = 32'h100; j_tgt = 32'h200; br_tgt = 32'h40;
    jr = 1'b1; jump = 1'b1; branch_taken = 1'b1;
    #1; chk("jr prio dut1", 32'(src[0]), 32'h3); chk("jr prio dut3", 32'(src[1]), 32'h3);
    step(); jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    chk("jr pc", pc[0], 32'h100);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!fl[1]) break;
      n++;
      if (n == 2) chk("jr flush1 single", 32'(fl[0]), 32'h0);
      stall = (n == 2);
      step();
    end
    stall = 1'b0;
    chk("flush3 with stall", 32'(n), 32'd4);
    j_tgt = 32'h18; jump = 1'b1;
    step(); jump = 1'b0; chk("j pc", pc[0], 32'h18);
    step(); step();
    chk("stall start dut1", pc[0], 32'h20); chk("stall start dut3", pc[1], 32'h20);
    stall = 1'b1; j_tgt = 32'h300; jump = 1'b1;
    repeat (3) begin
      #1; chk("stall write", 32'(wr[0]), 32'h0);
      step(); chk("stall hold", pc[0], 32'h20);
    end
    stall = 1'b0;
    #1; chk("jump after stall", 32'(src[0]), 32'h2); chk("jump in flush3", 32'(src[1]), 32'h0);
    step(); jump = 1'b0;
    chk("jump pc dut1", pc[0], 32'h300); chk("seq pc dut3", pc[1], 32'h24);
    step();
    j_tgt = 32'h24; jump = 1'b1;
    step(); jump = 1'b0; chk("j2 pc", pc[0], 32'h24);
    step(); step();
    chk("exc pc", pc[0], 32'h2C);
    exception = 1'b1; stall = 1'b1;
    #1; chk("exc src", 32'(src[0]), 32'h4); chk("exc write", 32'(wr[0]), 32'h1);
    step(); exception = 1'b0; stall = 1'b0;
    chk("exc vec", pc[0], EXC_VEC); chk("exc epc", epc[0], 32'h2C);
    chk("exc in_exc", 32'(ie[0]), 32'h1); chk("exc flush", 32'(fl[0]), 32'h1);
    step(); step();
    exception = 1'b1;
    #1; chk("nested masked", 32'(src[0]), 32'h0);
    step(); exception = 1'b0;
    chk("nested epc", epc[0], 32'h2C); chk("nested in_exc", 32'(ie[0]), 32'h1);
    exception = 1'b1; exc_clear = 1'b1;
    #1; chk("clear same cycle masked", 32'(src[0]), 32'h0);
    step(); exc_clear = 1'b0;
    chk("cleared", 32'(ie[0]), 32'h0);
    #1; chk("exc again src", 32'(src[0]), 32'h4);
    step(); exception = 1'b0;
    chk("exc again epc", epc[0], EXC_VEC + 32'd16); chk("exc again pc", pc[0], EXC_VEC);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async flush", 32'(fl[0]), 32'h0); chk("async flush3", 32'(fl[1]), 32'h0);
    chk("async pc", pc[0], 32'h0); chk("async write", 32'(wr[0]), 32'h0);
    chk("async in_exc", 32'(ie[0]), 32'h0); chk("async epc", epc[0], 32'h0);
    step();
    reset_n = 1'b1;
    #1; chk("reboot write", 32'(wr[0]), 32'h0);
    step(); chk("reboot pc", pc[0], 32'h0); chk("reboot run", 32'(wr[0]), 32'h1);
    step(); chk("reboot pc4", pc[0], 32'h4);
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
